// File: rtl/sample_buffer_pkg.sv
// Shared definitions for the sample/playback buffer family.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: playback_state_t, addr_width(), DEFAULT_BUFFER_DEPTH.
package sample_buffer_pkg;

    localparam int DEFAULT_BUFFER_DEPTH = 1024;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LOADED = 2'd1,
        PLAY   = 2'd2
    } playback_state_t;

    // Address bits needed to index 'depth' words; never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/playback_buffer_if.sv
// AXI-stream style bus: data word with valid/ready handshake and end-of-frame last.
// Latency: n/a (wiring only).
// Backpressure: a word transfers on a cycle where valid and ready are both high.
//
// Signals: data (DWIDTH), valid, ready, last.
// Modports: master drives data/valid/last, slave drives ready.
interface Axis_If #(
    parameter int DWIDTH = 128
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data appears the cycle after re is sampled.
// Backpressure: none; rdata holds its value while re is low.
//
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module bram_sdp
    import sample_buffer_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int  WIDTH = 128,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/playback_buffer.sv
// Waveform memory: loads a last-terminated stream, then replays it on data_out on command.
// Latency: start sampled in N -> playing in N+1 -> first data_out.valid in N+2; then 1 word/cycle.
// Backpressure: data_out.ready low freezes the output word; reads pause when the 2-entry skid is full.
//
// Ports: clk, reset (sync, active-high); data_in (load stream, slave); data_out (playback, master);
//        start/stop/clear pulses; loaded, playing status; length = stored word count.
// Build option: define PLAYBACK_BUFFER_LOOP_EN for continuous looping playback;
//               otherwise playback is one-shot and returns to LOADED after the last word.
module playback_buffer
    import sample_buffer_pkg::*;
#(
    parameter int  BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int  DWIDTH       = 128,
    localparam int AW           = addr_width(BUFFER_DEPTH),
    localparam int LW           = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    Axis_If.slave        data_in,
    Axis_If.master       data_out,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    output logic         loaded,
    output logic         playing,
    output logic [AW:0]  length
);

`ifdef PLAYBACK_BUFFER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [AW:0] DEPTH_W = LW'(BUFFER_DEPTH);

    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] dat;
    } skid_ent_t;

    playback_state_t state, state_nxt;

    // waddr saturates at BUFFER_DEPTH; its top bit marks "memory full, discard until last".
    logic [AW:0]       waddr;
    logic [AW:0]       raddr;
    logic [AW:0]       len_q;
    logic              stop_pend;   // stop seen while a word was held; wait for its accept
    logic              issue_done;  // one-shot: final word of the pass already read

    logic              rd_en;
    logic              rd_last;
    logic              rd_vld_q;
    logic              rd_last_q;
    logic [DWIDTH-1:0] rd_dat;

    skid_ent_t         ent0, ent1, new_ent;
    logic [1:0]        cnt;
    logic [2:0]        occ;

    logic              in_hs;
    logic              wr_en;
    logic              out_vld;
    logic              pop;
    logic              push;
    logic              credit_ok;
    logic              flush;
    logic              trunc;
    logic              set_pend;
    logic              do_clear;

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    assign data_in.ready  = (state == LOAD) && !reset;
    assign in_hs          = data_in.valid && data_in.ready;
    assign wr_en          = in_hs && !waddr[AW];

    assign out_vld        = (cnt != 2'd0);
    assign pop            = out_vld && data_out.ready;
    assign data_out.valid = out_vld;
    assign data_out.data  = ent0.dat;
    assign data_out.last  = ent0.last;

    assign loaded         = (state == LOADED);
    assign playing        = (state == PLAY);
    assign length         = len_q;

    assign rd_last        = (raddr == (len_q - 1'b1));

    // A read issued now lands in the skid two edges later. Words already
    // stored plus the one in flight, minus this cycle's accept, must leave
    // room for it.
    assign occ            = {1'b0, cnt} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign credit_ok      = (occ <= 3'd1);

    // Returning read data is dropped once a stop is in effect.
    assign push           = rd_vld_q && (state == PLAY) && !stop_pend;
    assign new_ent        = '{last: rd_last_q, dat: rd_dat};

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        flush     = 1'b0;
        trunc     = 1'b0;
        set_pend  = 1'b0;
        do_clear  = 1'b0;
        case (state)
            LOAD: begin
                if (in_hs && data_in.last) begin
                    state_nxt = LOADED;
                end
            end
            LOADED: begin
                if (clear) begin
                    state_nxt = LOAD;
                    do_clear  = 1'b1;
                end else if (start && !stop) begin
                    // First read goes out in the start cycle so the word is
                    // presented two cycles after start.
                    state_nxt = PLAY;
                    rd_en     = 1'b1;
                end
            end
            PLAY: begin
                if (stop_pend) begin
                    if (pop) begin
                        state_nxt = LOADED;
                        flush     = 1'b1;
                    end
                end else if (stop) begin
                    if (!out_vld || pop) begin
                        state_nxt = LOADED;
                        flush     = 1'b1;
                    end else begin
                        // Keep only the presented word; prefetched data is dropped.
                        set_pend = 1'b1;
                        trunc    = 1'b1;
                    end
                end else begin
                    rd_en = !issue_done && credit_ok;
                    if (!LOOP_EN && pop && ent0.last) begin
                        state_nxt = LOADED;
                        flush     = 1'b1;
                        rd_en     = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load side: write address and stored length
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr <= '0;
            len_q <= '0;
        end else if (do_clear) begin
            waddr <= '0;
            len_q <= '0;
        end else if (in_hs) begin
            if (data_in.last) begin
                waddr <= '0;
                len_q <= waddr[AW] ? DEPTH_W : (waddr + 1'b1);
            end else if (!waddr[AW]) begin
                waddr <= waddr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: address counter, in-flight tag, stop tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr      <= '0;
            issue_done <= 1'b0;
            stop_pend  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_last_q <= rd_last;
            end
            if (state_nxt != PLAY) begin
                raddr      <= '0;
                issue_done <= 1'b0;
                stop_pend  <= 1'b0;
            end else begin
                if (rd_en) begin
                    raddr <= rd_last ? '0 : (raddr + 1'b1);
                    if (rd_last && !LOOP_EN) begin
                        issue_done <= 1'b1;
                    end
                end
                if (set_pend) begin
                    stop_pend <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output skid; ent0 is the presented word
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (trunc) begin
            cnt <= 2'd1;
        end else begin
            if (pop) begin
                if (cnt == 2'd2) begin
                    ent0 <= ent1;
                    if (push) begin
                        ent1 <= new_ent;
                    end
                end else if (push) begin
                    ent0 <= new_ent;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    ent0 <= new_ent;
                end else begin
                    ent1 <= new_ent;
                end
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // ------------------------------------------------------------------
    // Waveform storage
    // ------------------------------------------------------------------
    bram_sdp #(
        .DEPTH (BUFFER_DEPTH),
        .WIDTH (DWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr[AW-1:0]),
        .wdata (data_in.data),
        .re    (rd_en),
        .raddr (raddr[AW-1:0]),
        .rdata (rd_dat)
    );

endmodule

// File: tb/tb_playback_buffer.sv
// Self-checking bench for playback_buffer with a queue/array reference model.
// Latency: n/a.
// Backpressure: randomised data_out.ready; holds checked while stalled.
module tb_playback_buffer;

    localparam int DEPTH = 1024;
    localparam int DW    = 128;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        clear   = 1'b0;
    logic        loaded;
    logic        playing;
    logic [10:0] length;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            model_len = 0;
    int            exp_idx   = 0;

    always #5 clk = ~clk;

    Axis_If #(.DWIDTH(DW)) in_if ();
    Axis_If #(.DWIDTH(DW)) out_if ();

    playback_buffer #(
        .BUFFER_DEPTH (DEPTH),
        .DWIDTH       (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (in_if),
        .data_out (out_if),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .loaded   (loaded),
        .playing  (playing),
        .length   (length)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load n words (sequence 0..n-1 or random), with random idle gaps.
    task automatic load_words(input int n, input bit seq);
        int            stalls;
        int            b;
        logic [DW-1:0] w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            w = seq ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
            if (i < DEPTH) model_mem[i] = w;
            if ($urandom_range(0, 4) == 0) begin
                in_if.valid = 1'b0;
                tick();
            end
            in_if.valid = 1'b1;
            in_if.data  = w;
            in_if.last  = (i == n - 1);
            b = 0;
            while (!in_if.ready && b < 10) begin
                tick();
                b++;
                stalls++;
            end
            tick();
        end
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        model_len   = (n < DEPTH) ? n : DEPTH;
        chk("load_stalls", 128'(stalls), 128'(0));
        chk("load_loaded", 128'(loaded), 128'(1));
        chk("load_length", 128'(length), 128'(model_len));
        chk("load_in_rdy", 128'(in_if.ready), 128'(0));
        chk("load_playing", 128'(playing), 128'(0));
    endtask

    task automatic start_play();
        exp_idx      = 0;
        out_if.ready = 1'b1;
        chk("pre_playing", 128'(playing), 128'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("playing_n1", 128'(playing), 128'(1));
        chk("vld_n1", 128'(out_if.valid), 128'(0));
        tick();
        chk("vld_n2", 128'(out_if.valid), 128'(1));
    endtask

    // Accept nwords words with ready asserted pct% of cycles; compare
    // each against the model sequence and check holds while stalled.
    task automatic collect(input int nwords, input int pct);
        int            got;
        int            cyc;
        bit            r;
        bit            stall;
        logic [DW-1:0] pd;
        logic          pl;
        got   = 0;
        cyc   = 0;
        stall = 1'b0;
        pd    = '0;
        pl    = 1'b0;
        while (got < nwords && cyc < nwords * 8 + 50) begin
            r = ($urandom_range(0, 99) < pct);
            if (stall) begin
                chk("hold_vld", 128'(out_if.valid), 128'(1));
                chk("hold_dat", out_if.data, pd);
                chk("hold_last", 128'(out_if.last), 128'(pl));
            end
            out_if.ready = r;
            if (out_if.valid && r) begin
                chk("dat", out_if.data, model_mem[exp_idx]);
                chk("last", 128'(out_if.last), 128'(exp_idx == model_len - 1));
                exp_idx = (exp_idx + 1 == model_len) ? 0 : exp_idx + 1;
                got++;
            end
            stall = out_if.valid && !r;
            pd    = out_if.data;
            pl    = out_if.last;
            tick();
            cyc++;
        end
        chk("words", 128'(got), 128'(nwords));
        if (pct == 100) chk("rate", 128'(cyc), 128'(nwords));
    endtask

    task automatic end_oneshot();
        chk("os_loaded", 128'(loaded), 128'(1));
        chk("os_playing", 128'(playing), 128'(0));
        chk("os_vld", 128'(out_if.valid), 128'(0));
        repeat (3) tick();
        chk("os_quiet", 128'(out_if.valid), 128'(0));
    endtask

    // Stall output, stop with the next word held, then release it.
    task automatic stop_and_drain();
        out_if.ready = 1'b0;
        tick();
        tick();
        chk("held_vld", 128'(out_if.valid), 128'(1));
        chk("held_dat", out_if.data, model_mem[exp_idx]);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_vld", 128'(out_if.valid), 128'(1));
        chk("stop_dat", out_if.data, model_mem[exp_idx]);
        chk("stop_playing", 128'(playing), 128'(1));
        out_if.ready = 1'b1;
        tick();
        chk("drain_vld", 128'(out_if.valid), 128'(0));
        chk("drain_loaded", 128'(loaded), 128'(1));
        chk("drain_playing", 128'(playing), 128'(0));
        repeat (4) tick();
        chk("drain_quiet", 128'(out_if.valid), 128'(0));
    endtask

    task automatic play_pass(input int loop_words, input int pct);
        start_play();
`ifdef PLAYBACK_BUFFER_LOOP_EN
        collect(loop_words, pct);
        stop_and_drain();
`else
        collect(model_len, pct);
        end_oneshot();
        if (loop_words < 0) $display("unused %0d", loop_words);
`endif
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b0;
        reset        = 1'b1;
        repeat (3) tick();
        chk("rst_in_rdy", 128'(in_if.ready), 128'(0));
        reset = 1'b0;
        #1;
        chk("in_rdy_after", 128'(in_if.ready), 128'(1));
        chk("rst_vld", 128'(out_if.valid), 128'(0));
        chk("rst_last", 128'(out_if.last), 128'(0));
        chk("rst_data", out_if.data, 128'(0));
        chk("rst_loaded", 128'(loaded), 128'(0));
        chk("rst_playing", 128'(playing), 128'(0));
        chk("rst_length", 128'(length), 128'(0));

        // start in LOAD is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load", 128'(playing), 128'(0));
        chk("still_load", 128'(in_if.ready), 128'(1));

        // sequential 0..7, full rate
        load_words(8, 1'b1);
        play_pass(24, 100);

        // random backpressure, 100 passes
`ifdef PLAYBACK_BUFFER_LOOP_EN
        play_pass(800, 50);
`else
        for (int p = 0; p < 100; p++) play_pass(0, 50);
`endif

        // start+stop together: stays LOADED
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_loaded", 128'(loaded), 128'(1));
        chk("ss_playing", 128'(playing), 128'(0));
        tick();
        chk("ss_vld", 128'(out_if.valid), 128'(0));

        // clear+start together: clear wins
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("cs_loaded", 128'(loaded), 128'(0));
        chk("cs_length", 128'(length), 128'(0));
        chk("cs_in_rdy", 128'(in_if.ready), 128'(1));
        chk("cs_playing", 128'(playing), 128'(0));

        // stop with word 5 held
        load_words(8, 1'b0);
        start_play();
        collect(5, 100);
        stop_and_drain();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_length", 128'(length), 128'(0));
        chk("clr_in_rdy", 128'(in_if.ready), 128'(1));
        chk("clr_loaded", 128'(loaded), 128'(0));

        // overflow: 1030 words into 1024
        load_words(1030, 1'b0);
        play_pass(1030, 100);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // reset mid-play, then reload
        load_words(3, 1'b0);
        start_play();
        collect(2, 100);
        reset = 1'b1;
        tick();
        chk("mid_rst_vld", 128'(out_if.valid), 128'(0));
        chk("mid_rst_playing", 128'(playing), 128'(0));
        chk("mid_rst_length", 128'(length), 128'(0));
        chk("mid_rst_loaded", 128'(loaded), 128'(0));
        chk("mid_rst_in_rdy", 128'(in_if.ready), 128'(0));
        reset = 1'b0;
        #1;
        chk("mid_rst_in_rdy_after", 128'(in_if.ready), 128'(1));
        load_words(3, 1'b0);
        play_pass(9, 100);

        // single-word waveform: every word carries last
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load_words(1, 1'b0);
        play_pass(4, 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
